// File: rtl/img_pkg.sv
// Shared image-pipeline types and defaults: pixel struct, sink FSM states,
// default frame geometry and a width helper for address/counter ports.
package img_pkg;

   localparam int unsigned IMG_HEIGHT = 768;
   localparam int unsigned IMG_WIDTH  = 512;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      DONE
   } state_t;

   // $clog2 that never yields a zero-width vector (degenerate 1-pixel frames).
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/img_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port
// (read-before-write on address collision). Contents are not reset.
module img_frame_ram
   import img_pkg::*;
#(
   parameter int unsigned DEPTH = IMG_WIDTH * IMG_HEIGHT,
   parameter int unsigned AW    = clog2_min1(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  rgb_t          i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [23:0]   o_rdata
);

   logic [23:0] r_mem [0:DEPTH-1];
   logic [23:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Only the output register is reset; the array itself stays uninitialised.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/image_write.sv
// Raster-order RGB pixel sink with valid/ready input, frame buffer and read port.
// Optional frame-count report when IMAGE_WRITE_DUMP_EN is defined (simulation only).
module image_write
  import img_pkg::*;
#(
  parameter int unsigned HEIGHT  = IMG_HEIGHT,
  parameter int unsigned WIDTH   = IMG_WIDTH,
  parameter              OUTFILE = "output.hex"
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   in_sof,
  input  logic [7:0]                             R,
  input  logic [7:0]                             G,
  input  logic [7:0]                             B,
  output logic                                   frame_done,
  input  logic                                   frame_ack,
  output logic                                   sof_err,
  output logic [clog2_min1(WIDTH*HEIGHT+1)-1:0]  pix_count,
  input  logic [clog2_min1(WIDTH*HEIGHT)-1:0]    rd_addr,
  output logic [23:0]                            rd_data
);

  localparam int unsigned NPIX = WIDTH * HEIGHT;
  localparam int unsigned AW   = clog2_min1(NPIX);
  localparam int unsigned PW   = clog2_min1(NPIX + 1);
  localparam int unsigned CW   = clog2_min1(WIDTH);
  localparam int unsigned RW   = clog2_min1(HEIGHT);

  // Position reached after accepting the first pixel of a frame.
  localparam logic [CW-1:0] FIRST_COL   = CW'((WIDTH > 1) ? 1 : 0);
  localparam logic [RW-1:0] FIRST_ROW   = RW'((WIDTH == 1 && HEIGHT > 1) ? 1 : 0);
  localparam logic [AW-1:0] FIRST_ADDR  = AW'((NPIX > 1) ? 1 : 0);
  localparam state_t        FIRST_STATE = (NPIX > 1) ? RECV : DONE;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_col, w_col_nxt;
  logic [RW-1:0]   r_row, w_row_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic [PW-1:0]   r_pix_count, w_pix_count_nxt;
  logic            r_sof_err, w_sof_err_nxt;

  logic            w_xfer;
  logic            w_last;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  rgb_t            w_pix;

  assign w_pix  = '{r: R, g: G, b: B};
  assign w_xfer = in_valid && (r_state != DONE);
  assign w_last = (r_row == RW'(HEIGHT - 1)) && (r_col == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_addr      <= '0;
      r_pix_count <= '0;
      r_sof_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_addr      <= w_addr_nxt;
      r_pix_count <= w_pix_count_nxt;
      r_sof_err   <= w_sof_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_col_nxt       = r_col;
    w_row_nxt       = r_row;
    w_addr_nxt      = r_addr;
    w_pix_count_nxt = r_pix_count;
    w_sof_err_nxt   = r_sof_err;
    w_we            = 1'b0;
    w_waddr         = r_addr;
    in_ready        = (r_state != DONE);
    frame_done      = (r_state == DONE);

    unique case (r_state)
      IDLE: begin
        if (w_xfer && in_sof) begin
          w_we            = 1'b1;
          w_waddr         = '0;
          w_col_nxt       = FIRST_COL;
          w_row_nxt       = FIRST_ROW;
          w_addr_nxt      = FIRST_ADDR;
          w_pix_count_nxt = PW'(1);
          w_state_nxt     = FIRST_STATE;
        end
      end
      RECV: begin
        if (w_xfer) begin
          w_we = 1'b1;
          if (in_sof) begin
            // Mid-frame SOF: flag it and treat this pixel as a fresh frame start.
            w_sof_err_nxt   = 1'b1;
            w_waddr         = '0;
            w_col_nxt       = FIRST_COL;
            w_row_nxt       = FIRST_ROW;
            w_addr_nxt      = FIRST_ADDR;
            w_pix_count_nxt = PW'(1);
          end else if (w_last) begin
            w_pix_count_nxt = r_pix_count + PW'(1);
            w_col_nxt       = '0;
            w_row_nxt       = '0;
            w_addr_nxt      = '0;
            w_state_nxt     = DONE;
          end else begin
            w_pix_count_nxt = r_pix_count + PW'(1);
            w_addr_nxt      = r_addr + AW'(1);
            if (r_col == CW'(WIDTH - 1)) begin
              w_col_nxt = '0;
              w_row_nxt = r_row + RW'(1);
            end else begin
              w_col_nxt = r_col + CW'(1);
            end
          end
        end
      end
      DONE: begin
        if (frame_ack) begin
          w_col_nxt       = '0;
          w_row_nxt       = '0;
          w_addr_nxt      = '0;
          w_pix_count_nxt = '0;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign sof_err   = r_sof_err;
  assign pix_count = r_pix_count;

  img_frame_ram #(
    .DEPTH (NPIX),
    .AW    (AW)
  ) u_ram (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_pix),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  logic w_unused_outfile;
  assign w_unused_outfile = ^OUTFILE;

`ifdef IMAGE_WRITE_DUMP_EN
  logic        r_dump;
  int unsigned r_frames;

  // r_dump is high on the first cycle in DONE, after the last pixel has landed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dump   <= 1'b0;
      r_frames <= 0;
    end else begin
      r_dump <= (r_state != DONE) && (w_state_nxt == DONE);
      if (r_dump) begin
        r_frames <= r_frames + 1;
        $display("image_write: frame %0d written", r_frames + 1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_image_write.sv
// Directed bench for image_write at WIDTH=4, HEIGHT=3: table-driven frame/backpressure/idle
// vectors plus hand sequences for read-before-write, mid-frame SOF, reset and gapped input.
module tb_image_write;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sof;
   logic [7:0]  R, G, B;
   logic        frame_done;
   logic        frame_ack;
   logic        sof_err;
   logic [3:0]  pix_count;
   logic [3:0]  rd_addr;
   logic [23:0] rd_data;

   int unsigned n_checks;
   int unsigned n_errors;

   image_write #(
      .HEIGHT  (3),
      .WIDTH   (4),
      .OUTFILE ("output.hex")
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sof     (in_sof),
      .R          (R),
      .G          (G),
      .B          (B),
      .frame_done (frame_done),
      .frame_ack  (frame_ack),
      .sof_err    (sof_err),
      .pix_count  (pix_count),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic        sof;
      logic        ack;
      logic [23:0] pix;
      logic        exp_ready;
      logic        exp_done;
      logic [3:0]  exp_pix;
   } vec_t;

   vec_t vecs [21];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [23:0] pix, input logic sof);
      in_valid  = 1'b1;
      in_sof    = sof;
      {R, G, B} = pix;
      step();
      in_valid  = 1'b0;
      in_sof    = 1'b0;
   endtask

   task automatic read_chk(input string name, input logic [3:0] addr, input logic [23:0] exp);
      rd_addr = addr;
      step();
      chk(name, {8'h0, rd_data}, {8'h0, exp});
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      frame_ack = 1'b0;
      {R, G, B} = '0;
      rd_addr   = '0;

      // Frame 1: 12 pixels {i,i+1,i+2}; DONE backpressure; ack; discarded idle pixels.
      for (int i = 0; i < 12; i++) begin
         vecs[i] = '{valid: 1'b1, sof: (i == 0), ack: 1'b0,
                     pix: {8'(i), 8'(i + 1), 8'(i + 2)},
                     exp_ready: (i != 11), exp_done: (i == 11), exp_pix: 4'(i + 1)};
      end
      for (int i = 12; i < 17; i++) begin
         vecs[i] = '{valid: 1'b1, sof: 1'b0, ack: 1'b0, pix: 24'hFFFFFF,
                     exp_ready: 1'b0, exp_done: 1'b1, exp_pix: 4'd12};
      end
      vecs[17] = '{valid: 1'b0, sof: 1'b0, ack: 1'b1, pix: 24'h0,
                   exp_ready: 1'b1, exp_done: 1'b0, exp_pix: 4'd0};
      for (int i = 18; i < 21; i++) begin
         vecs[i] = '{valid: 1'b1, sof: 1'b0, ack: 1'b0, pix: 24'hAAAAAA,
                     exp_ready: 1'b1, exp_done: 1'b0, exp_pix: 4'd0};
      end

      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready",   {31'h0, in_ready},   32'h1);
      chk("reset_done",    {31'h0, frame_done}, 32'h0);
      chk("reset_sof_err", {31'h0, sof_err},    32'h0);
      chk("reset_pix",     {28'h0, pix_count},  32'h0);
      chk("reset_rd_data", {8'h0, rd_data},     32'h0);
      rst = 1'b0;

      for (int i = 0; i < 21; i++) begin
         in_valid  = vecs[i].valid;
         in_sof    = vecs[i].sof;
         frame_ack = vecs[i].ack;
         {R, G, B} = vecs[i].pix;
         step();
         chk($sformatf("vec%0d_ready", i), {31'h0, in_ready},   {31'h0, vecs[i].exp_ready});
         chk($sformatf("vec%0d_done", i),  {31'h0, frame_done}, {31'h0, vecs[i].exp_done});
         chk($sformatf("vec%0d_pix", i),   {28'h0, pix_count},  {28'h0, vecs[i].exp_pix});
      end
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      frame_ack = 1'b0;

      read_chk("f1_addr5",  4'd5,  24'h050607);
      read_chk("f1_addr0",  4'd0,  24'h000102);
      read_chk("f1_addr3",  4'd3,  24'h030405);
      read_chk("f1_addr11", 4'd11, 24'h0B0C0D);

      // Frame 2: read-before-write on address 0, then a mid-frame SOF after 7 pixels.
      rd_addr = 4'd0;
      send(24'h200000, 1'b1);
      chk("rbw_old_data", {8'h0, rd_data}, 32'h000102);
      chk("f2_pix1", {28'h0, pix_count}, 32'd1);
      read_chk("f2_addr0_new", 4'd0, 24'h200000);
      for (int k = 1; k < 7; k++) send(24'h200000 + 24'(k), 1'b0);
      chk("f2_pix7", {28'h0, pix_count}, 32'd7);
      chk("f2_sof_err_pre", {31'h0, sof_err}, 32'h0);
      send(24'h300000, 1'b1);
      chk("midsof_err",   {31'h0, sof_err},   32'h1);
      chk("midsof_pix",   {28'h0, pix_count}, 32'd1);
      chk("midsof_ready", {31'h0, in_ready},  32'h1);
      for (int k = 1; k < 11; k++) send(24'h300000 + 24'(k), 1'b0);
      chk("midsof_not_done", {31'h0, frame_done}, 32'h0);
      send(24'h30000B, 1'b0);
      chk("midsof_done",      {31'h0, frame_done}, 32'h1);
      chk("midsof_pix12",     {28'h0, pix_count},  32'd12);
      chk("midsof_err_stuck", {31'h0, sof_err},    32'h1);
      read_chk("f2_addr0",  4'd0,  24'h300000);
      read_chk("f2_addr6",  4'd6,  24'h300006);
      read_chk("f2_addr11", 4'd11, 24'h30000B);
      frame_ack = 1'b1;
      step();
      frame_ack = 1'b0;
      chk("f2_ack_done",    {31'h0, frame_done}, 32'h0);
      chk("f2_ack_sof_err", {31'h0, sof_err},    32'h1);

      // Reset mid-frame after 6 pixels.
      send(24'h500000, 1'b1);
      for (int k = 1; k < 6; k++) send(24'h500000 + 24'(k), 1'b0);
      chk("prerst_pix", {28'h0, pix_count}, 32'd6);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_ready",   {31'h0, in_ready},   32'h1);
      chk("rst_done",    {31'h0, frame_done}, 32'h0);
      chk("rst_pix",     {28'h0, pix_count},  32'h0);
      chk("rst_sof_err", {31'h0, sof_err},    32'h0);
      send(24'h777777, 1'b0);
      chk("rst_idle_discard", {28'h0, pix_count}, 32'h0);
      read_chk("rst_mem_kept", 4'd0, 24'h500000);

      // Gapped input: one transfer every third cycle over a full frame.
      for (int k = 0; k < 12; k++) begin
         send(24'h60A050 + 24'(k) * 24'h010101, (k == 0));
         chk($sformatf("gap%0d_done", k), {31'h0, frame_done}, {31'h0, (k == 11)});
         repeat (2) step();
         chk($sformatf("gap%0d_done_hold", k), {31'h0, frame_done}, {31'h0, (k == 11)});
      end
      chk("gap_pix", {28'h0, pix_count}, 32'd12);
      for (int k = 0; k < 12; k++) begin
         read_chk($sformatf("gap_rd%0d", k), 4'(k), 24'h60A050 + 24'(k) * 24'h010101);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
